muldiv_sequencer: RTL and testbench
===================================

# muldiv_sequencer

Iterative multi-cycle sequencer for the RV32M multiply/divide instructions, sitting beside the ALU in the execute stage of the pipelined core. It takes the already-forwarded execute operands and the M-extension function code, then runs a radix-2 shift-add multiply or restoring divide over DATA_WIDTH cycles. While it works, it asserts a stall request to the hazard unit so that the F/D/E stages hold. It returns the result with a one-cycle done strobe, on the cycle the pipeline is released.

## Interface
- DATA_WIDTH, default 32: operand and result width.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- StartE  input  1  a valid M-extension instruction is in the execute stage; it stays high while the stage is stalled.
- MulDivOpE  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- SrcAE  input  DATA_WIDTH  forwarded rs1 value (multiplicand or dividend).
- SrcBE  input  DATA_WIDTH  forwarded rs2 value (multiplier or divisor).
- FlushE  input  1  execute-stage flush; aborts any operation in progress.
- StallMD  output  1  stall request to the hazard unit (freezes F/D/E).
- DoneE  output  1  one-cycle strobe: MulDivResultE is valid for the current execute instruction.
- MulDivResultE  output  DATA_WIDTH  registered result, held until the next operation completes.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - When StartE=1 and FlushE=0, latch the operands, the op, and the sign flags.
  - Operand sign handling:
    - Signed operands (MULH: both; MULHSU: A only; DIV/REM: both) are converted to magnitude.
    - MUL treats both operands as unsigned; its low word is sign-independent.
  - Load the cycle counter with DATA_WIDTH and go to BUSY.
- Special divide cases go from IDLE directly to DONE, without iterating:
  - divisor==0: quotient = all ones; remainder = dividend (SrcAE unchanged).
  - Signed overflow (DIV/REM, SrcAE=0x80000000, SrcBE=0xFFFFFFFF): quotient = 0x80000000; remainder = 0.
- BUSY:
  - Each cycle performs one iteration:
    - Multiply: if the multiplier LSB is set, add the multiplicand to the 2·DATA_WIDTH-bit product accumulator, then shift right.
    - Divide: shift the remainder left with the next dividend bit, trial-subtract the divisor, and set the quotient bit if the result is non-negative.
  - Decrement the counter; when it reaches 0, go to DONE.
- DONE:
  - Negate the magnitude result when the result sign requires it:
    - Product sign = signA XOR signB.
    - Quotient sign = signA XOR signB.
    - Remainder sign = signA.
  - Select the result word:
    - MUL: low word.
    - MULH/MULHSU/MULHU: high word.
    - DIV/DIVU: quotient.
    - REM/REMU: remainder.
  - Register the result into MulDivResultE, pulse DoneE, and go to IDLE unconditionally. The StartE still high in this cycle belongs to the finishing instruction and never restarts.
- StallMD = ((state==IDLE & StartE) | state==BUSY) & ~FlushE. It is combinational and 0 in DONE, so the pipeline advances in the DONE cycle.
- FlushE=1 in any state:
  - Next state is IDLE.
  - DoneE is not asserted for the aborted operation.
  - MulDivResultE keeps its old value.
  - StallMD is 0 in the flush cycle.
- StartE=1 in IDLE on the cycle after DONE is a new instruction and starts immediately; back-to-back operations are supported.
- Reset (asynchronous, at any time, including mid-BUSY):
  - state = IDLE, counter = 0, accumulators = 0.
  - MulDivResultE = 0, DoneE = 0.
  - StallMD = 0 while StartE=0.

## Timing
- Cycle 0 is the first cycle StartE=1 is seen in IDLE.
- Normal operation:
  - StallMD is high in cycles 0..DATA_WIDTH (33 cycles for 32-bit).
  - BUSY occupies cycles 1..DATA_WIDTH.
  - DONE, DoneE=1 and the new MulDivResultE all occur in cycle DATA_WIDTH+1 (cycle 33).
- Special divide cases: StallMD is high in cycle 0 only; DoneE and the result appear in cycle 1.
- Minimum spacing between two starts: the second start is no earlier than one cycle after DONE.
- DoneE is never high in two consecutive cycles.
- The combinational paths from StartE/FlushE to StallMD carry no other logic.

## Test plan
- MUL, SrcA=7, SrcB=0xFFFFFFFD (-3) -> StallMD high for cycles 0–32; cycle 33 DoneE=1, MulDivResultE=0xFFFFFFEB. MULHU with 0xFFFFFFFF·0xFFFFFFFF -> 0xFFFFFFFE; MULH with the same operands -> 0x00000000.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2; each completes at cycle 33.
- DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM with the same operands -> 0; each has DoneE at cycle 1 and StallMD high in cycle 0 only.
- Back-to-back MUL 3·4 followed by DIVU 9/3 (StartE held high through both) -> DoneE at cycle 33 with result 12, then DoneE at cycle 67 with result 3; no spurious restart in either DONE cycle.
- FlushE pulsed at cycle 10 of a DIV -> cycle 10 StallMD=0, cycle 11 state IDLE; no DoneE; MulDivResultE unchanged. A new StartE after the flush completes normally.
- rst_n asserted low at cycle 15 of a MULHU -> all state and outputs zero immediately. After release, with StartE low: StallMD=0, DoneE=0, MulDivResultE=0.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
// Iterative RV32M multiply/divide unit for the execute stage. Runs a radix-2
// shift-add multiply or a restoring divide over DATA_WIDTH cycles. While the
// operation is in progress it holds F/D/E with a stall request.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   StartE         M-extension instruction present in execute (held while stalled)
//   MulDivOpE      funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   SrcAE, SrcBE   forwarded rs1 / rs2 operands
//   FlushE         execute flush, aborts the current operation
//   StallMD        combinational stall request to the hazard unit
//   DoneE          one-cycle strobe, MulDivResultE is valid for this instruction
//   MulDivResultE  registered result, held until the next completion
module muldiv_sequencer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  StartE,
  input  logic [2:0]            MulDivOpE,
  input  logic [DATA_WIDTH-1:0] SrcAE,
  input  logic [DATA_WIDTH-1:0] SrcBE,
  input  logic                  FlushE,
  output logic                  StallMD,
  output logic                  DoneE,
  output logic [DATA_WIDTH-1:0] MulDivResultE
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic            sign_a_q, sign_a_d;
  logic            sign_b_q, sign_b_d;
  // Multiplicand for multiplies, divisor for divides.
  logic [W-1:0]    mag_q, mag_d;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide:   {partial remainder, remaining dividend bits / quotient bits}.
  logic [2*W-1:0]  acc_q, acc_d;
  logic [W-1:0]    result_q, result_d;
  logic            done_q, done_d;

  // Operand decode in IDLE
  logic            in_div, a_signed, b_signed, in_sa, in_sb;
  logic [W-1:0]    in_mag_a, in_mag_b;
  logic            div_zero, div_ovf;
  logic [W-1:0]    special_res;

  // One iteration step and final result formation
  logic [W:0]      mul_sum;
  logic [2*W-1:0]  mul_step;
  logic [W:0]      rem_shift, trial;
  logic [2*W-1:0]  div_step;
  logic [2*W-1:0]  step_acc;
  logic [2*W-1:0]  prod_fin;
  logic [W-1:0]    quo_fin, rem_fin, final_res;

  always_comb begin
    in_div   = MulDivOpE[2];
    a_signed = (MulDivOpE == 3'd1) || (MulDivOpE == 3'd2) ||
               (MulDivOpE == 3'd4) || (MulDivOpE == 3'd6);
    b_signed = (MulDivOpE == 3'd1) || (MulDivOpE == 3'd4) || (MulDivOpE == 3'd6);
    in_sa    = a_signed & SrcAE[W-1];
    in_sb    = b_signed & SrcBE[W-1];
    in_mag_a = in_sa ? -SrcAE : SrcAE;
    in_mag_b = in_sb ? -SrcBE : SrcBE;
    div_zero = (SrcBE == '0);
    // Only the signed divide ops (DIV=4, REM=6) have bit 0 clear.
    div_ovf  = ~MulDivOpE[0] && (SrcAE == {1'b1, {(W-1){1'b0}}}) && (SrcBE == '1);
    // funct3 bit 1 distinguishes REM/REMU from DIV/DIVU.
    if (div_zero) special_res = MulDivOpE[1] ? SrcAE : '1;
    else          special_res = MulDivOpE[1] ? '0 : SrcAE;
  end

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, mag_q} : '0);
    mul_step  = {mul_sum, acc_q[W-1:1]};
    rem_shift = acc_q[2*W-1:W-1];
    trial     = rem_shift - {1'b0, mag_q};
    // A borrow out means the divisor did not fit: keep the shifted remainder.
    if (trial[W]) div_step = {rem_shift[W-1:0], acc_q[W-2:0], 1'b0};
    else          div_step = {trial[W-1:0],     acc_q[W-2:0], 1'b1};
    step_acc  = op_q[2] ? div_step : mul_step;

    prod_fin  = (sign_a_q ^ sign_b_q) ? -step_acc : step_acc;
    quo_fin   = (sign_a_q ^ sign_b_q) ? -step_acc[W-1:0] : step_acc[W-1:0];
    rem_fin   = sign_a_q ? -step_acc[2*W-1:W] : step_acc[2*W-1:W];
    case (op_q)
      3'd0:          final_res = prod_fin[W-1:0];
      3'd1, 3'd2,
      3'd3:          final_res = prod_fin[2*W-1:W];
      3'd4, 3'd5:    final_res = quo_fin;
      default:       final_res = rem_fin;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    mag_d    = mag_q;
    acc_d    = acc_q;
    result_d = result_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (StartE) begin
          op_d     = MulDivOpE;
          sign_a_d = in_sa;
          sign_b_d = in_sb;
          if (in_div && (div_zero || div_ovf)) begin
            result_d = special_res;
            done_d   = 1'b1;
            state_d  = DONE;
          end else begin
            mag_d   = in_div ? in_mag_b : in_mag_a;
            acc_d   = in_div ? {{W{1'b0}}, in_mag_a} : {{W{1'b0}}, in_mag_b};
            cnt_d   = CW'(W);
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        acc_d = step_acc;
        cnt_d = cnt_q - CW'(1);
        // Last iteration: the result register and strobe land together in DONE.
        if (cnt_q == CW'(1)) begin
          result_d = final_res;
          done_d   = 1'b1;
          state_d  = DONE;
        end
      end
      default: begin
        // StartE still high here belongs to the finishing instruction.
        state_d = IDLE;
      end
    endcase

    if (FlushE) begin
      state_d  = IDLE;
      done_d   = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      mag_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      mag_q    <= mag_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign StallMD       = (((state_q == IDLE) & StartE) | (state_q == BUSY)) & ~FlushE;
  assign DoneE         = done_q;
  assign MulDivResultE = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        StartE = 1'b0;
  logic [2:0]  MulDivOpE = 3'd0;
  logic [31:0] SrcAE = 32'd0;
  logic [31:0] SrcBE = 32'd0;
  logic        FlushE = 1'b0;
  logic        StallMD;
  logic        DoneE;
  logic [31:0] MulDivResultE;

  muldiv_sequencer #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .StartE(StartE), .MulDivOpE(MulDivOpE),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .FlushE(FlushE),
    .StallMD(StallMD), .DoneE(DoneE), .MulDivResultE(MulDivResultE)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          done_cyc;
    int          stalls;
    string       name;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        chk_quiet = 1'b0;
  logic        chk_nostall = 1'b0;
  logic        chk_drain = 1'b0;
  logic [31:0] hold_val = 32'd0;
  logic [31:0] last_res = 32'd0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: compares every DoneE against the scoreboard head, plus the
  // quiet-window checks requested by the stimulus.
  initial begin
    exp_t e;
    int   stall_cnt;
    logic prev_done;
    stall_cnt = 0;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n || FlushE) stall_cnt = 0;
      else if (StallMD)     stall_cnt++;
      if (DoneE) begin
        check("done_single_pulse", {31'd0, prev_done}, 32'd0);
        if (sb_q.size() == 0) begin
          check("spurious_done", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check({e.name, "_result"}, MulDivResultE, e.res);
          check({e.name, "_done_cycle"}, cyc, e.done_cyc);
          check({e.name, "_stall_cycles"}, stall_cnt, e.stalls);
          $display("txn %s result=%h done_cycle=%0d stalls=%0d", e.name, MulDivResultE, cyc, stall_cnt);
        end
        stall_cnt = 0;
      end
      if (chk_quiet) begin
        check("quiet_doneE", {31'd0, DoneE}, 32'd0);
        check("quiet_result", MulDivResultE, hold_val);
        check("quiet_stall", {31'd0, StallMD}, 32'd0);
      end
      if (chk_nostall) check("flush_stall", {31'd0, StallMD}, 32'd0);
      if (chk_drain)   check("scoreboard_drained", sb_q.size(), 32'd0);
      prev_done = DoneE;
    end
  end

  task automatic start_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat,
                          input bit push);
    exp_t e;
    @(posedge clk); #1;
    StartE = 1'b1; MulDivOpE = op; SrcAE = a; SrcBE = b;
    if (push) begin
      e.res = exp; e.done_cyc = cyc + lat; e.stalls = lat; e.name = name;
      sb_q.push_back(e);
    end
  endtask

  // Leaves StartE high through the DONE cycle, as the stalled pipeline would.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    start_op(name, op, a, b, exp, lat, 1'b1);
    repeat (lat) @(posedge clk);
    #1;
    last_res = exp;
  endtask

  task automatic release_op();
    @(posedge clk); #1;
    StartE = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst_n = 1'b0; hold_val = 32'd0; chk_quiet = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk_quiet = 1'b0;

    // Multiplies
    run_op("MUL_7_m3",      3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33); release_op();
    run_op("MULHU_ff_ff",   3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33); release_op();
    run_op("MULH_m1_m1",    3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33); release_op();
    run_op("MULHSU_m1_ff",  3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33); release_op();
    run_op("MULH_min_2",    3'd1, 32'h80000000, 32'd2,        32'hFFFFFFFF, 33); release_op();

    // Divides
    run_op("DIV_m7_2",      3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33); release_op();
    run_op("REM_m7_2",      3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33); release_op();
    run_op("DIVU_100_7",    3'd5, 32'd100,      32'd7,        32'd14,       33); release_op();
    run_op("REMU_100_7",    3'd7, 32'd100,      32'd7,        32'd2,        33); release_op();
    run_op("DIV_7_m2",      3'd4, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33); release_op();
    run_op("REM_7_m2",      3'd6, 32'd7,        32'hFFFFFFFE, 32'd1,        33); release_op();

    // Special divide cases
    run_op("DIVU_5_0",      3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1); release_op();
    run_op("REMU_5_0",      3'd7, 32'd5,        32'd0,        32'd5,        1); release_op();
    run_op("REM_m5_0",      3'd6, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1); release_op();
    run_op("DIV_ovf",       3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1); release_op();
    run_op("REM_ovf",       3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1); release_op();

    // Back-to-back with StartE held high through both
    run_op("B2B_MUL_3_4",   3'd0, 32'd3,        32'd4,        32'd12,       33);
    run_op("B2B_DIVU_9_3",  3'd5, 32'd9,        32'd3,        32'd3,        33); release_op();

    // Flush at cycle 10 of a DIV
    start_op("DIV_flushed", 3'd4, 32'hFFFFFF9C, 32'd7, 32'd0, 33, 1'b0);
    repeat (10) @(posedge clk);
    #1 FlushE = 1'b1; chk_nostall = 1'b1;
    @(posedge clk);
    #1 FlushE = 1'b0; StartE = 1'b0; chk_nostall = 1'b0;
    hold_val = last_res; chk_quiet = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk_quiet = 1'b0;
    run_op("DIVU_after_flush", 3'd5, 32'd100, 32'd7, 32'd14, 33); release_op();

    // Asynchronous reset at cycle 15 of a MULHU
    start_op("MULHU_reset", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 33, 1'b0);
    repeat (15) @(posedge clk);
    #1 rst_n = 1'b0; StartE = 1'b0; hold_val = 32'd0; chk_quiet = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk_quiet = 1'b0; last_res = 32'd0;
    run_op("MUL_after_reset", 3'd0, 32'd3, 32'd4, 32'd12, 33); release_op();

    // Every expectation must have been consumed
    @(posedge clk);
    #1 chk_drain = 1'b1;
    @(posedge clk);
    #1 chk_drain = 1'b0;
    @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
